// File: rtl/seq_div_32bit.sv
// seq_div_32bit: restoring sequential divider, one quotient bit per clock,
// signed (truncating toward zero) or unsigned, with start/busy/done handshake.
module seq_div_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic             r_qneg;
    logic             r_rneg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fit;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_p_next;
    logic             w_last;
    // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign w_abs_a  = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_abs_b  = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
    // P < D always holds, so the shifted value is below 2D and WIDTH+1 bits keep the trial sign exact.
    assign w_shift  = {r_p, r_q[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_d};
    assign w_fit    = ~w_trial[WIDTH];
    assign w_q_next = {r_q[WIDTH-2:0], w_fit};
    assign w_p_next = w_fit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_last   = r_count == CW'(WIDTH - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_p         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_p         <= '0;
                    r_q         <= w_abs_a;
                    r_d         <= w_abs_b;
                    r_count     <= '0;
                    r_qneg      <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_rneg      <= is_signed & dividend[WIDTH-1];
                    div_by_zero <= divisor == '0;
                    if (divisor == '0) begin
                        quotient  <= '1;
                        remainder <= dividend;
                        done      <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_p     <= w_p_next;
                    r_q     <= w_q_next;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        quotient  <= r_qneg ? -w_q_next : w_q_next;
                        remainder <= r_rneg ? -w_p_next : w_p_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div_32bit.sv
// tb_seq_div_32bit: directed vectors checked against a transaction-level arithmetic model
// every cycle, plus hand-computed literal results and latencies.
module tb_seq_div_32bit;
    localparam int W = 32;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    int           n_cmp = 0;
    int           n_bad = 0;
    time          t0 = 0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic         m_dz = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    int           m_left = 0;

    seq_div_32bit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == '0) return {{W{1'b1}}, a};
        if (!s) return {a / b, a % b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        return {q[W-1:0], r[W-1:0]};
    endfunction

    // Timeline model: accepted work publishes WIDTH edges later, divide-by-zero immediately.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q = '0; m_r = '0; m_dz = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_q = p_q; m_r = p_r; m_busy = 1'b0; m_done = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start) begin
            {p_q, p_r} = ref_div(dividend, divisor, is_signed);
            m_dz = divisor == '0;
            if (divisor == '0) begin
                m_q = p_q; m_r = p_r; m_done = 1'b1;
            end else begin
                m_busy = 1'b1; m_left = W;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", W'(busy), W'(m_busy));
        chk("done", W'(done), W'(m_done));
        chk("quotient", quotient, m_q);
        chk("remainder", remainder, m_r);
        chk("div_by_zero", W'(div_by_zero), W'(m_dz));
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        dividend = a; divisor = b; is_signed = s; start = 1'b1; t0 = $time;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = ~s;
    endtask

    task automatic wait_done(input string name, input int lat, input logic [W-1:0] q,
                             input logic [W-1:0] r, input logic dz);
        int k = 0;
        while (done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({name, " latency"}, W'(($time - t0) / 10), W'(lat));
        chk({name, " q"}, quotient, q);
        chk({name, " r"}, remainder, r);
        chk({name, " dz"}, W'(div_by_zero), W'(dz));
        chk({name, " model q"}, m_q, q);
        chk({name, " model r"}, m_r, r);
    endtask

    task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input int lat, input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        issue(a, b, s);
        wait_done(name, lat, q, r, dz);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset busy", W'(busy), '0);
        chk("reset done", W'(done), '0);
        chk("reset q", quotient, '0);
        chk("reset r", remainder, '0);
        chk("reset dz", W'(div_by_zero), '0);
        rst_n = 1'b1;
        op("u 100/7", 100, 7, 0, 33, 14, 2, 0);
        op("s -7/2", 32'hFFFF_FFF9, 2, 1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        op("u -7/2", 32'hFFFF_FFF9, 2, 0, 33, 32'h7FFF_FFFC, 1, 0);
        op("u div0", 32'h1234_5678, 0, 0, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1);
        op("s min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1, 33, 32'h8000_0000, 0, 0);
        op("u max/1", 32'hFFFF_FFFF, 1, 0, 33, 32'hFFFF_FFFF, 0, 0);
        op("s div0", 32'h8000_0001, 0, 1, 1, 32'hFFFF_FFFF, 32'h8000_0001, 1);
        op("s 7/-2", 7, 32'hFFFF_FFFE, 1, 33, 32'hFFFF_FFFD, 1, 0);
        op("s -7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1, 33, 3, 32'hFFFF_FFFF, 0);
        op("u max/max-1", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 33, 1, 1, 0);
        op("u min/max", 32'h8000_0000, 32'hFFFF_FFFF, 0, 33, 0, 32'h8000_0000, 0);
        issue(100, 7, 0);
        repeat (4) @(negedge clk);
        dividend = 50; divisor = 5; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("hs first", 33, 14, 2, 0);
        dividend = 32'hDEAD; divisor = 0; start = 1'b1;
        issue(1000, 10, 0);
        wait_done("hs second", 33, 100, 0, 0);
        issue(100, 7, 0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async busy", W'(busy), '0);
        chk("async done", W'(done), '0);
        chk("async q", quotient, '0);
        chk("async r", remainder, '0);
        chk("async dz", W'(div_by_zero), '0);
        @(negedge clk);
        rst_n = 1'b1;
        op("after reset 9/3", 9, 3, 0, 33, 3, 0, 0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d mismatched so far", n_bad);
        $fatal(1);
    end
endmodule
